// File: rtl/write_slave_pkg.sv
// Shared AXI write/read-side definitions: burst and response codes, FSM encodings.
package write_slave_pkg;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] BurstRsvd  = 2'b11;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StData = 2'b01,
        StResp = 2'b10
    } state_e;

    // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; shared by both slave sides.
module axi_addr_gen
    import write_slave_pkg::*;
#(
    parameter int unsigned buswidth = 32
) (
    input  logic [buswidth-1:0] i_addr,
    input  logic [1:0]          i_size,
    input  logic [3:0]          i_len,
    input  logic [1:0]          i_burst,
    output logic [buswidth-1:0] o_next
);

    logic [buswidth-1:0] w_one;
    logic [buswidth-1:0] w_incr;
    logic [buswidth-1:0] w_sum;
    logic [buswidth-1:0] w_mask;

    always_comb begin
        w_one  = {{(buswidth-1){1'b0}}, 1'b1};
        w_incr = w_one << i_size;
        w_sum  = i_addr + w_incr;
        // Wrap block is (len+1)<<size bytes, naturally aligned.
        w_mask = ((({{(buswidth-4){1'b0}}, i_len}) + w_one) << i_size) - w_one;
        case (i_burst)
            BurstIncr: o_next = w_sum;
            BurstWrap: o_next = (i_addr & ~w_mask) | (w_sum & w_mask);
            default:   o_next = i_addr;
        endcase
    end

endmodule

// File: rtl/write_slave.sv
// AXI3 write slave: one burst in flight, zero-latency beat writes to a simple memory port.
module write_slave
    import write_slave_pkg::*;
#(
    parameter int unsigned buswidth = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [1:0]            AWID,
    input  logic [buswidth-1:0]   AWADDR,
    input  logic [3:0]            AWLEN,
    input  logic [1:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic [1:0]            AWLOCK,
    input  logic [3:0]            AWCACHE,
    input  logic [2:0]            AWPROT,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [1:0]            WID,
    input  logic [buswidth-1:0]   WDATA,
    input  logic [buswidth/8-1:0] WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [1:0]            BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [buswidth-1:0]   address_out,
    output logic                  memwrite,
    output logic [buswidth-1:0]   data_out,
    output logic [buswidth/8-1:0] strb_out
);

    state_e              r_state;
    state_e              w_state_d;
    logic                r_live;
    logic [1:0]          r_id;
    logic [buswidth-1:0] r_addr;
    logic [3:0]          r_len;
    logic [1:0]          r_size;
    logic [1:0]          r_burst;
    logic [3:0]          r_cnt;
    logic                r_berr;
    logic                r_perr;

    logic                w_aw_fire;
    logic                w_w_fire;
    logic                w_last_beat;
    logic [buswidth-1:0] w_next_addr;
    logic                w_unused;

    assign w_unused = ^{AWLOCK, AWCACHE, AWPROT};

    axi_addr_gen #(
        .buswidth (buswidth)
    ) u_addr_gen (
        .i_addr  (r_addr),
        .i_size  (r_size),
        .i_len   (r_len),
        .i_burst (r_burst),
        .o_next  (w_next_addr)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        AWREADY   = 1'b0;
        WREADY    = 1'b0;
        BVALID    = 1'b0;
        case (r_state)
            StIdle: begin
                // r_live keeps AWREADY low until the first edge out of reset.
                AWREADY = r_live;
                if (AWVALID && r_live) w_state_d = StData;
            end
            StData: begin
                WREADY = 1'b1;
                if (WVALID && w_last_beat) w_state_d = StResp;
            end
            StResp: begin
                BVALID = 1'b1;
                if (BREADY) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign w_aw_fire   = AWVALID & AWREADY;
    assign w_w_fire    = WVALID & WREADY;
    assign w_last_beat = (r_cnt == r_len);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_live  <= 1'b0;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_berr  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_aw_fire) begin
                r_id    <= AWID;
                r_addr  <= AWADDR;
                r_len   <= AWLEN;
                r_size  <= AWSIZE;
                r_burst <= AWBURST;
                r_cnt   <= '0;
                r_berr  <= (AWBURST == BurstRsvd) ||
                           ((AWBURST == BurstWrap) && !wrap_len_ok(AWLEN));
                r_perr  <= 1'b0;
            end
            if (w_w_fire) begin
                r_cnt  <= r_cnt + 4'd1;
                r_addr <= w_next_addr;
                if ((WID != r_id) || (WLAST != w_last_beat)) r_perr <= 1'b1;
            end
        end
    end

    assign memwrite    = w_w_fire & ~r_berr;
    assign address_out = r_addr;
    assign data_out    = WDATA;
    assign strb_out    = WSTRB;
    assign BID         = r_id;
    assign BRESP       = (BVALID && (r_berr || r_perr)) ? RespSlverr : RespOkay;

endmodule

// File: tb/tb_write_slave.sv
// Scoreboard bench for write_slave: expected beats/responses queued at drive time.
module tb_write_slave;

    logic        ACLK    = 1'b0;
    logic        ARESETn = 1'b0;
    logic [1:0]  AWID    = '0;
    logic [31:0] AWADDR  = '0;
    logic [3:0]  AWLEN   = '0;
    logic [1:0]  AWSIZE  = '0;
    logic [1:0]  AWBURST = '0;
    logic [1:0]  AWLOCK  = '0;
    logic [3:0]  AWCACHE = '0;
    logic [2:0]  AWPROT  = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [1:0]  WID     = '0;
    logic [31:0] WDATA   = '0;
    logic [3:0]  WSTRB   = '0;
    logic        WLAST   = 1'b0;
    logic        WVALID  = 1'b0;
    logic        WREADY;
    logic [1:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY  = 1'b0;
    logic [31:0] address_out;
    logic        memwrite;
    logic [31:0] data_out;
    logic [3:0]  strb_out;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] resp;
    } b_t;

    wr_t wr_q[$];
    b_t  b_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    write_slave #(
        .buswidth (32)
    ) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .AWID        (AWID),
        .AWADDR      (AWADDR),
        .AWLEN       (AWLEN),
        .AWSIZE      (AWSIZE),
        .AWBURST     (AWBURST),
        .AWLOCK      (AWLOCK),
        .AWCACHE     (AWCACHE),
        .AWPROT      (AWPROT),
        .AWVALID     (AWVALID),
        .AWREADY     (AWREADY),
        .WID         (WID),
        .WDATA       (WDATA),
        .WSTRB       (WSTRB),
        .WLAST       (WLAST),
        .WVALID      (WVALID),
        .WREADY      (WREADY),
        .BID         (BID),
        .BRESP       (BRESP),
        .BVALID      (BVALID),
        .BREADY      (BREADY),
        .address_out (address_out),
        .memwrite    (memwrite),
        .data_out    (data_out),
        .strb_out    (strb_out)
    );

    always #5 ACLK = ~ACLK;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Write-port monitor and handshake exclusivity check.
    always @(negedge ACLK) begin
        if (ARESETn) begin
            check_eq("excl", 64'(({1'b0, AWREADY} + {1'b0, WREADY} + {1'b0, BVALID}) > 2'd1), 0);
        end
        if (memwrite) begin
            if (wr_q.size() == 0) begin
                check_eq("unexp_wr", {32'h0, address_out}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check_eq("wr_addr", address_out, e.addr);
                check_eq("wr_data", data_out, e.data);
                check_eq("wr_strb", strb_out, e.strb);
            end
        end
    end

    task automatic aw_send(input logic [1:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] size, input logic [1:0] burst);
        int n;
        AWID    = id;
        AWADDR  = addr;
        AWLEN   = len;
        AWSIZE  = size;
        AWBURST = burst;
        AWVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!AWREADY && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        check_eq("aw_ready", AWREADY, 1);
        @(posedge ACLK);
        #1 AWVALID = 1'b0;
        check_eq("aw_then_w", {AWREADY, WREADY, BVALID}, 3'b010);
    endtask

    task automatic w_send(input logic [1:0] id, input logic [31:0] data, input logic [3:0] strb,
                          input logic last, input bit exp_wr, input logic [31:0] exp_addr);
        int n;
        WID    = id;
        WDATA  = data;
        WSTRB  = strb;
        WLAST  = last;
        WVALID = 1'b1;
        if (exp_wr) wr_q.push_back('{addr: exp_addr, data: data, strb: strb});
        n = 0;
        @(negedge ACLK);
        while (!WREADY && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        check_eq("w_ready", WREADY, 1);
        @(posedge ACLK);
        #1;
        WVALID = 1'b0;
        WLAST  = 1'b0;
    endtask

    task automatic b_check(input int hold);
        b_t e;
        int n;
        if (b_q.size() == 0) begin
            check_eq("b_q_empty", 1, 0);
            return;
        end
        e = b_q.pop_front();
        n = 0;
        @(negedge ACLK);
        while (!BVALID && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        check_eq("bvalid", BVALID, 1);
        if (BVALID) begin
            for (int i = 0; i < hold; i++) begin
                check_eq("b_hold_id", BID, e.id);
                check_eq("b_hold_resp", BRESP, e.resp);
                check_eq("b_hold_aw", AWREADY, 0);
                @(negedge ACLK);
                check_eq("b_hold_valid", BVALID, 1);
            end
            check_eq("bid", BID, e.id);
            check_eq("bresp", BRESP, e.resp);
            BREADY = 1'b1;
            @(posedge ACLK);
            #1 BREADY = 1'b0;
            check_eq("b_done", {AWREADY, BVALID}, 2'b10);
        end
    endtask

    logic [31:0] wrap_addrs [4];

    initial begin
        wrap_addrs = '{32'h108, 32'h10C, 32'h100, 32'h104};

        // Reset values while ARESETn is low.
        #2;
        check_eq("rst_hs", {AWREADY, WREADY, BVALID}, 3'b000);
        check_eq("rst_b", {BID, BRESP}, 4'h0);
        check_eq("rst_mw", memwrite, 0);
        @(posedge ACLK);
        #1 ARESETn = 1'b1;
        @(negedge ACLK);
        check_eq("aw_pre_edge", AWREADY, 0);
        @(negedge ACLK);
        check_eq("aw_post_edge", AWREADY, 1);
        @(posedge ACLK);
        #1;

        // INCR, with BREADY held off for 5 cycles.
        b_q.push_back('{id: 2'd2, resp: 2'b00});
        aw_send(2'd2, 32'h100, 4'd3, 2'd2, 2'b01);
        for (int i = 0; i < 4; i++)
            w_send(2'd2, 32'hA000_0000 + 32'(i), 4'hF, i == 3, 1'b1, 32'h100 + 32'(4 * i));
        b_check(5);

        // WRAP.
        b_q.push_back('{id: 2'd1, resp: 2'b00});
        aw_send(2'd1, 32'h108, 4'd3, 2'd2, 2'b10);
        for (int i = 0; i < 4; i++)
            w_send(2'd1, 32'hB000_0000 + 32'(i), 4'hF, i == 3, 1'b1, wrap_addrs[i]);
        b_check(0);

        // FIXED with varying strobes.
        b_q.push_back('{id: 2'd0, resp: 2'b00});
        aw_send(2'd0, 32'h40, 4'd2, 2'd2, 2'b00);
        for (int i = 0; i < 3; i++)
            w_send(2'd0, 32'hC000_0000 + 32'(i), 4'(1 << i), i == 2, 1'b1, 32'h40);
        b_check(0);

        // Early WLAST: beats still written, SLVERR.
        b_q.push_back('{id: 2'd3, resp: 2'b10});
        aw_send(2'd3, 32'h200, 4'd3, 2'd2, 2'b01);
        for (int i = 0; i < 4; i++)
            w_send(2'd3, 32'hD000_0000 + 32'(i), 4'hF, (i == 1) || (i == 3), 1'b1,
                   32'h200 + 32'(4 * i));
        b_check(0);

        // Reserved burst type: no writes, SLVERR.
        b_q.push_back('{id: 2'd1, resp: 2'b10});
        aw_send(2'd1, 32'h80, 4'd1, 2'd2, 2'b11);
        for (int i = 0; i < 2; i++)
            w_send(2'd1, 32'hE000_0000 + 32'(i), 4'hF, i == 1, 1'b0, 32'h0);
        b_check(0);

        // WID mismatch on the second beat: writes happen, SLVERR.
        b_q.push_back('{id: 2'd1, resp: 2'b10});
        aw_send(2'd1, 32'h500, 4'd1, 2'd0, 2'b01);
        w_send(2'd1, 32'h1111_0000, 4'h1, 1'b0, 1'b1, 32'h500);
        w_send(2'd2, 32'h1111_0001, 4'h1, 1'b1, 1'b1, 32'h501);
        b_check(0);

        // WRAP with an illegal length: no writes, SLVERR.
        b_q.push_back('{id: 2'd2, resp: 2'b10});
        aw_send(2'd2, 32'h600, 4'd2, 2'd2, 2'b10);
        for (int i = 0; i < 3; i++)
            w_send(2'd2, 32'hF000_0000 + 32'(i), 4'hF, i == 2, 1'b0, 32'h0);
        b_check(0);

        // WVALID while idle is ignored.
        WVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check_eq("idle_wready", WREADY, 0);
        end
        @(posedge ACLK);
        #1 WVALID = 1'b0;

        // Reset after the first beat aborts the burst.
        aw_send(2'd3, 32'h400, 4'd3, 2'd2, 2'b01);
        w_send(2'd3, 32'h2222_0000, 4'hF, 1'b0, 1'b1, 32'h400);
        #1 ARESETn = 1'b0;
        #1;
        check_eq("mid_rst_out", {AWREADY, WREADY, BVALID, BID, BRESP, memwrite}, 0);
        check_eq("mid_rst_addr", address_out, 0);
        @(posedge ACLK);
        #1 ARESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            check_eq("abort_no_b", BVALID, 0);
        end
        @(posedge ACLK);
        #1;

        // Next burst completes normally.
        b_q.push_back('{id: 2'd1, resp: 2'b00});
        aw_send(2'd1, 32'h300, 4'd1, 2'd2, 2'b01);
        for (int i = 0; i < 2; i++)
            w_send(2'd1, 32'h3333_0000 + 32'(i), 4'hF, i == 1, 1'b1, 32'h300 + 32'(4 * i));
        b_check(0);

        repeat (2) @(negedge ACLK);
        check_eq("wr_q_drained", wr_q.size(), 0);
        check_eq("b_q_drained", b_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
